traffic_light_ctrl_n: RTL

- Parametrised N-way intersection controller; successor to the fixed 4-way, fixed-timing sequencer.
- Cycles GREEN -> YELLOW -> ALL-RED per approach.
- Selects the next approach round-robin from vehicle demand, and supports emergency preemption.
- Sits between the sensor/preempt inputs and the lamp drivers; all timing is in clk cycles.

---
 rtl/traffic_light_ctrl_n.sv | 128 ++++++++++++
 1 files changed

// File: rtl/traffic_light_ctrl_n.sv
// N-way intersection controller: GREEN -> YELLOW -> ALLRED per approach, round-robin
// selection from vehicle demand, with emergency preemption.
module traffic_light_ctrl_n #(
  parameter int NUM_DIR     = 4,
  parameter int DIR_W       = $clog2(NUM_DIR),
  parameter int CNT_W       = 8,
  parameter int GREEN_TIME  = 16,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_DIR-1:0] car_req,
  input  logic               emerg_req,
  input  logic [DIR_W-1:0]   emerg_dir,
  output logic [DIR_W-1:0]   active_dir,
  output logic [1:0]         phase,
  output logic [CNT_W-1:0]   count,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10
  } phase_t;

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_TIME - 1);

  phase_t             ph_q, ph_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIR_W-1:0]   dir_q, dir_d, next_dir;
  logic               emerg_vld;
  logic               found;

  // Approach d+k modulo NUM_DIR, for 0 <= k <= NUM_DIR.
  function automatic logic [DIR_W-1:0] step_dir(input logic [DIR_W-1:0] d, input int k);
    int s;
    s = int'(d) + k;
    if (s >= NUM_DIR) s = s - NUM_DIR;
    return DIR_W'(s);
  endfunction

  // Out-of-range preempt targets are treated as no request at all.
  assign emerg_vld = emerg_req && ({1'b0, emerg_dir} < (DIR_W+1)'(NUM_DIR));

  always_comb begin
    next_dir = step_dir(dir_q, 1);
    found    = 1'b0;
    for (int i = 1; i <= NUM_DIR; i++) begin
      if (!found && car_req[step_dir(dir_q, i)]) begin
        next_dir = step_dir(dir_q, i);
        found    = 1'b1;
      end
    end
    if (emerg_vld) next_dir = emerg_dir;
  end

  always_comb begin
    ph_d  = ph_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (en) begin
      case (ph_q)
        PH_GREEN: begin
          // A preempt for the served approach freezes the count to extend green.
          if (emerg_vld) begin
            if (emerg_dir != dir_q) begin
              ph_d  = PH_YELLOW;
              cnt_d = '0;
            end
          end else if (cnt_q == G_LAST) begin
            ph_d  = PH_YELLOW;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PH_YELLOW: begin
          if (cnt_q == Y_LAST) begin
            ph_d  = PH_ALLRED;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PH_ALLRED: begin
          if (cnt_q == A_LAST) begin
            ph_d  = PH_GREEN;
            cnt_d = '0;
            dir_d = next_dir;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          ph_d  = PH_GREEN;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= PH_GREEN;
      cnt_q <= '0;
      dir_q <= '0;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign active_dir = dir_q;
  assign phase      = ph_q;
  assign count      = cnt_q;
  assign green      = (ph_q == PH_GREEN)  ? (NUM_DIR'(1) << dir_q) : '0;
  assign yellow     = (ph_q == PH_YELLOW) ? (NUM_DIR'(1) << dir_q) : '0;
  assign red        = ~(green | yellow);

endmodule
